// File: rtl/vending_pkg.sv
// Shared vending definitions: controller/dispenser state encoding, coin values
// and default actuator timing.
package vending_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BOTTLE,
      ST_NICKEL,
      ST_DIME,
      ST_FAULT
   } state_t;

   localparam int unsigned NICKEL_VALUE           = 5;
   localparam int unsigned DIME_VALUE             = 10;
   localparam int unsigned QUARTER_VALUE          = 25;
   localparam int unsigned DEFAULT_PULSE_CYCLES   = 4;
   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1000;

   // Nickels always go out before dimes.
   function automatic state_t next_step(input logic nickel_pending, input logic dime_pending);
      if (nickel_pending) return ST_NICKEL;
      if (dime_pending)   return ST_DIME;
      return ST_IDLE;
   endfunction

endpackage

// File: rtl/change_dispenser_actuator_step.sv
// One mechanism step: fixed-length actuator pulse, remembered acknowledgement
// and a timeout measured from pulse start.
module actuator_step #(
   parameter int unsigned PULSE_CYCLES   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic start,
   input  logic active,
   input  logic ack,
   output logic drive,
   output logic done,
   output logic timeout
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + PULSE_CYCLES + 1);
   localparam logic [CW-1:0] PULSE_LEN   = CW'(PULSE_CYCLES);
   localparam logic [CW-1:0] PULSE_END   = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_END = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;
   logic          acked;
   logic          ack_seen;

   // start arrives on the edge that enters a step, so acks from the previous step are dropped.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt   <= '0;
         acked <= 1'b0;
      end else if (start) begin
         cnt   <= '0;
         acked <= 1'b0;
      end else if (active) begin
         if (cnt != '1) cnt <= cnt + CW'(1);
         if (ack) acked <= 1'b1;
      end
   end

   assign ack_seen = acked | ack;
   assign drive    = active && (cnt < PULSE_LEN);
   assign done     = active && ack_seen && (cnt >= PULSE_END);
   assign timeout  = active && !ack_seen && (cnt == TIMEOUT_END);

endmodule

// File: rtl/change_dispenser.sv
// Sequences bottle drop and change ejection against mechanism acks, tracks
// hopper inventory and reports busy/fault/missed status.
module change_dispenser
   import vending_pkg::*;
#(
   parameter int unsigned PULSE_CYCLES   = DEFAULT_PULSE_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int unsigned INV_W          = 8,
   parameter int unsigned INV_INIT       = 50
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             deliver,
   input  logic             give_nickel,
   input  logic             give_dime,
   input  logic             give_doubledime,
   input  logic             bottle_done,
   input  logic             coin_sensed,
   input  logic             refill_nickel,
   input  logic             refill_dime,
   input  logic [INV_W-1:0] refill_count,
   input  logic             clear_fault,
   output logic             bottle_out,
   output logic             eject_nickel,
   output logic             eject_dime,
   output logic             busy,
   output logic             fault,
   output logic             missed,
   output logic [INV_W-1:0] nickel_count,
   output logic [INV_W-1:0] dime_count,
   output logic             nickel_empty,
   output logic             dime_empty
);

   state_t           state, state_next;
   logic             nickels_left, nickels_left_next;
   logic [1:0]       dimes_left, dimes_left_next;
   logic             step_start, step_active, step_ack;
   logic             step_drive, step_done, step_timeout;
   logic             dec_nickel, dec_dime;
   logic [INV_W-1:0] nickel_next, dime_next;

   function automatic logic [INV_W-1:0] inv_update(input logic [INV_W-1:0] count,
                                                   input logic refill,
                                                   input logic [INV_W-1:0] amount,
                                                   input logic dec);
      logic [INV_W:0] sum;
      sum = {1'b0, count} + (refill ? {1'b0, amount} : '0);
      if (dec && (sum != '0)) sum = sum - (INV_W+1)'(1);
      if (sum[INV_W]) return '1;
      return sum[INV_W-1:0];
   endfunction

   assign step_active = (state == ST_BOTTLE) || (state == ST_NICKEL) || (state == ST_DIME);
   assign step_ack    = (state == ST_BOTTLE) ? bottle_done : coin_sensed;
   assign dec_nickel  = (state == ST_NICKEL) && step_done;
   assign dec_dime    = (state == ST_DIME) && step_done;
   assign nickel_next = inv_update(nickel_count, refill_nickel, refill_count, dec_nickel);
   assign dime_next   = inv_update(dime_count, refill_dime, refill_count, dec_dime);

   actuator_step #(
      .PULSE_CYCLES  (PULSE_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_step (
      .clock  (clock),
      .reset_n(reset_n),
      .start  (step_start),
      .active (step_active),
      .ack    (step_ack),
      .drive  (step_drive),
      .done   (step_done),
      .timeout(step_timeout)
   );

   always_comb begin
      state_next        = state;
      nickels_left_next = nickels_left;
      dimes_left_next   = dimes_left;
      step_start        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (deliver) begin
               nickels_left_next = give_nickel;
               dimes_left_next   = {1'b0, give_dime} + {give_doubledime, 1'b0};
               state_next        = ST_BOTTLE;
            end
         end
         ST_BOTTLE: begin
            if (step_timeout)   state_next = ST_FAULT;
            else if (step_done) state_next = next_step(nickels_left, dimes_left != 2'd0);
         end
         ST_NICKEL: begin
            if (step_timeout) state_next = ST_FAULT;
            else if (step_done) begin
               nickels_left_next = 1'b0;
               state_next        = next_step(1'b0, dimes_left != 2'd0);
            end
         end
         ST_DIME: begin
            if (step_timeout) state_next = ST_FAULT;
            else if (step_done) begin
               dimes_left_next = dimes_left - 2'd1;
               state_next      = next_step(1'b0, dimes_left_next != 2'd0);
            end
         end
         ST_FAULT: begin
            if (clear_fault) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase

      // An empty hopper is judged on post-update inventory, so a same-cycle refill still counts.
      if (((state_next == ST_NICKEL) && (nickel_next == '0)) ||
          ((state_next == ST_DIME) && (dime_next == '0)))
         state_next = ST_FAULT;
      if (state_next == ST_FAULT) begin
         nickels_left_next = 1'b0;
         dimes_left_next   = 2'd0;
      end

      step_start = ((state_next == ST_BOTTLE) || (state_next == ST_NICKEL) || (state_next == ST_DIME)) &&
                   ((state_next != state) || step_done);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         nickels_left <= 1'b0;
         dimes_left   <= 2'd0;
         missed       <= 1'b0;
         nickel_count <= INV_W'(INV_INIT);
         dime_count   <= INV_W'(INV_INIT);
      end else begin
         state        <= state_next;
         nickels_left <= nickels_left_next;
         dimes_left   <= dimes_left_next;
         missed       <= deliver && (state != ST_IDLE);
         nickel_count <= nickel_next;
         dime_count   <= dime_next;
      end
   end

   assign bottle_out   = (state == ST_BOTTLE) && step_drive;
   assign eject_nickel = (state == ST_NICKEL) && step_drive;
   assign eject_dime   = (state == ST_DIME) && step_drive;
   assign busy         = (state != ST_IDLE);
   assign fault        = (state == ST_FAULT);
   assign nickel_empty = (nickel_count == '0);
   assign dime_empty   = (dime_count == '0);

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench: stimulus queues expected actuator/status events, a negedge
// monitor pops and compares them as the dispenser produces them.
module tb_change_dispenser;

   localparam int K_BOTTLE = 0;
   localparam int K_NICKEL = 1;
   localparam int K_DIME   = 2;
   localparam int K_FAULT  = 3;
   localparam int K_MISSED = 4;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       deliver = 1'b0, give_nickel = 1'b0, give_dime = 1'b0, give_doubledime = 1'b0;
   logic       bottle_done = 1'b0, coin_sensed = 1'b0;
   logic       refill_nickel = 1'b0, refill_dime = 1'b0;
   logic [7:0] refill_count = 8'd0;
   logic       clear_fault = 1'b0;
   logic       bottle_out, eject_nickel, eject_dime, busy, fault, missed;
   logic [7:0] nickel_count, dime_count;
   logic       nickel_empty, dime_empty;

   typedef struct {
      int kind;
      int len;
   } ev_t;

   ev_t exp_q[$];
   int  total = 0;
   int  bad = 0;
   int  bottle_delay = -1;
   int  coin_delay = -1;

   change_dispenser #(
      .PULSE_CYCLES  (4),
      .TIMEOUT_CYCLES(20),
      .INV_W         (8),
      .INV_INIT      (50)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .deliver        (deliver),
      .give_nickel    (give_nickel),
      .give_dime      (give_dime),
      .give_doubledime(give_doubledime),
      .bottle_done    (bottle_done),
      .coin_sensed    (coin_sensed),
      .refill_nickel  (refill_nickel),
      .refill_dime    (refill_dime),
      .refill_count   (refill_count),
      .clear_fault    (clear_fault),
      .bottle_out     (bottle_out),
      .eject_nickel   (eject_nickel),
      .eject_dime     (eject_dime),
      .busy           (busy),
      .fault          (fault),
      .missed         (missed),
      .nickel_count   (nickel_count),
      .dime_count     (dime_count),
      .nickel_empty   (nickel_empty),
      .dime_empty     (dime_empty)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int kind, input int len);
      ev_t e;
      e.kind = kind;
      e.len  = len;
      exp_q.push_back(e);
   endtask

   task automatic report(input int kind, input int len);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event: got kind=%0d len=%0d expected none", kind, len);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.len != len) begin
            bad++;
            $display("FAIL event: got kind=%0d len=%0d expected kind=%0d len=%0d",
                     kind, len, e.kind, e.len);
         end
      end
   endtask

   // Monitor: actuator pulses reported on their falling edge with their length.
   logic [2:0] mon_prev = 3'b000;
   logic       mon_prev_fault = 1'b0;
   int         run_len[3] = '{0, 0, 0};
   always @(negedge clock) begin
      logic [2:0] cur;
      cur = {eject_dime, eject_nickel, bottle_out};
      if (!reset_n) begin
         mon_prev       = 3'b000;
         mon_prev_fault = 1'b0;
         for (int i = 0; i < 3; i++) run_len[i] = 0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (cur[i]) run_len[i]++;
            else if (mon_prev[i]) begin
               report(i, run_len[i]);
               run_len[i] = 0;
            end
         end
         if (fault && !mon_prev_fault) report(K_FAULT, 0);
         if (missed) report(K_MISSED, 0);
         mon_prev       = cur;
         mon_prev_fault = fault;
      end
   end

   // Mechanism model: ack a configurable number of cycles after the actuator rises.
   logic [2:0] rsp_prev = 3'b000;
   int         rsp_cycle = 0;
   int         rsp_last = 3;
   always @(negedge clock) begin
      logic [2:0] cur, rise;
      cur  = {eject_dime, eject_nickel, bottle_out};
      rise = cur & ~rsp_prev;
      if (!reset_n) begin
         bottle_done = 1'b0;
         coin_sensed = 1'b0;
         rsp_cycle   = 0;
         rsp_last    = 3;
         rsp_prev    = 3'b000;
      end else begin
         if (rise != 3'b000) begin
            rsp_cycle = 0;
            rsp_last  = rise[0] ? 0 : 1;
         end else rsp_cycle++;
         bottle_done = (rsp_last == 0) && (rsp_cycle == bottle_delay);
         coin_sensed = (rsp_last == 1) && (rsp_cycle == coin_delay);
         rsp_prev    = cur;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic vend(input logic n, input logic d, input logic dd);
      deliver = 1'b1; give_nickel = n; give_dime = d; give_doubledime = dd;
      tick();
      deliver = 1'b0; give_nickel = 1'b0; give_dime = 1'b0; give_doubledime = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      check(name, busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      repeat (3) tick();
      check("rst_bottle_out", bottle_out, 0);
      check("rst_eject_nickel", eject_nickel, 0);
      check("rst_eject_dime", eject_dime, 0);
      check("rst_busy", busy, 0);
      check("rst_fault", fault, 0);
      check("rst_missed", missed, 0);
      check("rst_nickel_count", nickel_count, 50);
      check("rst_dime_count", dime_count, 50);
      check("rst_empty", {nickel_empty, dime_empty}, 0);
      reset_n = 1'b1;
      tick();

      // Plain vend, ack during the pulse: IDLE again PULSE_CYCLES after start.
      bottle_delay = 2; coin_delay = 1;
      push(K_BOTTLE, 4);
      vend(1'b0, 1'b0, 1'b0);
      check("t1_bottle_next_cycle", bottle_out, 1);
      repeat (3) tick();
      check("t1_busy_last_step_cycle", busy, 1);
      tick();
      check("t1_idle_after_pulse", busy, 0);
      repeat (3) tick();
      check("t1_nickel_count", nickel_count, 50);
      check("t1_dime_count", dime_count, 50);
      check("t1_events_done", exp_q.size(), 0);

      // Bottle, nickel, dime back to back.
      bottle_delay = 1; coin_delay = 1;
      push(K_BOTTLE, 4); push(K_NICKEL, 4); push(K_DIME, 4);
      vend(1'b1, 1'b1, 1'b0);
      wait_idle("t2_idle", 100);
      repeat (3) tick();
      check("t2_nickel_count", nickel_count, 49);
      check("t2_dime_count", dime_count, 49);
      check("t2_events_done", exp_q.size(), 0);

      // Double dime with late acks; a second deliver mid-sequence is reported and dropped.
      bottle_delay = 5; coin_delay = 5;
      push(K_MISSED, 0); push(K_BOTTLE, 4); push(K_DIME, 4); push(K_DIME, 4);
      vend(1'b0, 1'b0, 1'b1);
      repeat (2) tick();
      deliver = 1'b1;
      tick();
      deliver = 1'b0;
      wait_idle("t3_idle", 100);
      repeat (6) tick();
      check("t3_dropped_request", busy, 0);
      check("t3_dime_count", dime_count, 47);
      check("t3_nickel_count", nickel_count, 49);
      check("t3_events_done", exp_q.size(), 0);

      // No coin ack: fault TIMEOUT_CYCLES after the nickel pulse starts.
      bottle_delay = 1; coin_delay = -1;
      push(K_BOTTLE, 4); push(K_NICKEL, 4); push(K_FAULT, 0);
      vend(1'b1, 1'b0, 1'b0);
      k = 0;
      while (!eject_nickel && k < 50) begin
         @(negedge clock);
         k++;
      end
      check("t4_nickel_started", eject_nickel, 1);
      k = 0;
      while (!fault && k < 100) begin
         @(negedge clock);
         k++;
      end
      check("t4_timeout_cycles", k, 20);
      check("t4_eject_low_in_fault", eject_nickel, 0);
      check("t4_busy_in_fault", busy, 1);
      tick();
      repeat (2) tick();
      check("t4_fault_holds", fault, 1);
      clear_fault = 1'b1;
      tick();
      clear_fault = 1'b0;
      check("t4_cleared_busy", busy, 0);
      check("t4_cleared_fault", fault, 0);
      check("t4_nickel_count", nickel_count, 49);
      check("t4_events_done", exp_q.size(), 0);

      // Async reset in the middle of a dime pulse.
      bottle_delay = 5; coin_delay = 5;
      push(K_BOTTLE, 4);
      vend(1'b0, 1'b1, 1'b0);
      k = 0;
      while (!eject_dime && k < 50) begin
         @(negedge clock);
         k++;
      end
      check("t6_dime_started", eject_dime, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_eject_dime_async", eject_dime, 0);
      check("t6_busy", busy, 0);
      check("t6_dime_count", dime_count, 50);
      check("t6_nickel_count", nickel_count, 50);
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      check("t6_events_done", exp_q.size(), 0);

      // Drain the dime hopper with double-dime vends.
      for (int i = 0; i < 25; i++) begin
         push(K_BOTTLE, 4); push(K_DIME, 4); push(K_DIME, 4);
         vend(1'b0, 1'b0, 1'b1);
         wait_idle("drain_idle", 200);
         repeat (2) tick();
      end
      check("drain_dime_count", dime_count, 0);
      check("drain_dime_empty", dime_empty, 1);
      check("drain_nickel_empty", nickel_empty, 0);

      // Empty dime hopper: fault on entering DIME, no dime pulse.
      push(K_BOTTLE, 4); push(K_FAULT, 0);
      vend(1'b0, 1'b1, 1'b0);
      k = 0;
      while (!fault && k < 100) begin
         tick();
         k++;
      end
      check("t5_fault", fault, 1);
      check("t5_eject_dime", eject_dime, 0);
      clear_fault = 1'b1;
      tick();
      clear_fault = 1'b0;
      check("t5_cleared", busy, 0);
      refill_dime = 1'b1; refill_count = 8'd10;
      tick();
      refill_dime = 1'b0;
      check("t5_refill_10", dime_count, 10);
      check("t5_not_empty", dime_empty, 0);
      refill_dime = 1'b1; refill_count = 8'd255;
      tick();
      refill_dime = 1'b0;
      check("t5_refill_saturate", dime_count, 255);
      refill_nickel = 1'b1; refill_dime = 1'b1; refill_count = 8'd3;
      tick();
      refill_nickel = 1'b0; refill_dime = 1'b0;
      check("t5_dual_refill_nickel", nickel_count, 53);
      check("t5_dual_refill_dime", dime_count, 255);

      repeat (4) tick();
      check("final_events_done", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Actuator-side counterpart of the coin-accepting vending controller.
- Consumes its one-cycle deliver/give_* outputs and sequences the physical bottle drop and change-coin ejections against mechanism acknowledgements, with per-step timeouts.
- Tracks nickel and dime hopper inventory.
- Reports busy, fault and missed-request status to the front panel.

Parameters:
PULSE_CYCLES, 4, actuator pulse length in clock cycles (>=1)
TIMEOUT_CYCLES, 1000, maximum cycles from pulse start to acknowledgement
INV_W, 8, width of each hopper inventory counter
INV_INIT, 50, inventory value loaded at reset (nickels and dimes)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
deliver  in  1  vend request; sampled in IDLE
give_nickel  in  1  change request: 1 nickel
give_dime  in  1  change request: 1 dime
give_doubledime  in  1  change request: 2 dimes
bottle_done  in  1  bottle-chute sensor, synchronous one-cycle pulse
coin_sensed  in  1  coin-exit sensor, synchronous one-cycle pulse
refill_nickel  in  1  add refill_count to nickel inventory
refill_dime  in  1  add refill_count to dime inventory
refill_count  in  INV_W  refill amount
clear_fault  in  1  leave FAULT state
bottle_out  out  1  bottle-release actuator
eject_nickel  out  1  nickel-hopper actuator
eject_dime  out  1  dime-hopper actuator
busy  out  1  high whenever state != IDLE
fault  out  1  high in FAULT
missed  out  1  one-cycle pulse: request arrived while not IDLE
nickel_count  out  INV_W  nickel inventory
dime_count  out  INV_W  dime inventory
nickel_empty  out  1  nickel_count == 0
dime_empty  out  1  dime_count == 0

Behaviour:
Reset (async, reset_n low):
- state = IDLE.
- All actuator and status outputs = 0.
- Both counts = INV_INIT; empty flags follow the counts.

Request capture:
- Edge with state IDLE and deliver = 1: latch nickels_left = give_nickel and dimes_left = give_dime + 2*give_doubledime (range 0..3; 3 accepted though never generated). Next state BOTTLE.
- give_* without deliver are ignored.
- deliver = 1 while not IDLE: missed = 1 on the following cycle; the request is dropped.

State machine:
- States: IDLE, BOTTLE, NICKEL, DIME, FAULT.
- BOTTLE, NICKEL, DIME are "step" states.
- The step's actuator (bottle_out, eject_nickel, eject_dime) is high for exactly the first PULSE_CYCLES cycles of the step, then low.
- A cycle counter starts at 0 on step entry. The ack (bottle_done for BOTTLE, coin_sensed for coins) is monitored from the first cycle.
- An ack arriving during the pulse is remembered. The step completes at the later of pulse end and ack.
- Extra acks beyond the first in a step are ignored.
- No ack by counter == TIMEOUT_CYCLES-1: go to FAULT; the actuator drops immediately.
- On coin-step completion: decrement that step's *_left and the matching inventory.

Successor after each step completes:
- NICKEL if nickels_left > 0.
- Else DIME if dimes_left > 0.
- Else IDLE.
- Nickels are always dispensed before dimes.

Entering a coin step with that inventory == 0:
- Go to FAULT instead, with no actuator pulse.

FAULT:
- All actuators low; fault = 1; busy = 1.
- Stays until clear_fault = 1, then next state IDLE.
- Pending *_left values are discarded.

Inventory:
- Refill adds refill_count, saturating at 2^INV_W-1.
- A refill and a decrement in the same cycle apply net (count + refill - 1), saturating.
- Both refills may assert together. Refill is allowed in any state.

Latency:
- Fastest vend (no change, ack during the pulse): deliver edge -> bottle_out high on the next cycle; back in IDLE PULSE_CYCLES cycles later.

Decomposition:
- Shared package `vending_pkg` holds:
  - the state enum typedef;
  - the coin values (5, 10, 25);
  - default pulse and timeout constants. The vending controller also uses this package.
- One natural sub-module, `actuator_step`: pulse generator, ack latch and timeout counter. Inputs: start, ack. Outputs: drive, done, timeout. Instantiated once and reused by all step states.

Test Plan:
1. Reset with INV_INIT=50 -> all outputs 0, counts 50. Then deliver=1 only, bottle_done at step cycle 2 -> bottle_out high 4 cycles, back to IDLE; counts unchanged.
2. deliver+give_nickel+give_dime, acks at step cycle 1 each -> bottle_out pulse, then eject_nickel pulse, then eject_dime pulse; nickel_count=49, dime_count=49.
3. deliver+give_doubledime -> two eject_dime pulses; dime_count 50->48. Also deliver asserted mid-sequence -> missed pulses once and that request is not served.
4. No coin_sensed during NICKEL with TIMEOUT_CYCLES=20 -> fault=1 after 20 step cycles with eject_nickel low; clear_fault -> IDLE with busy=0.
5. dime_count preloaded to 0 (INV_INIT=0), request with give_dime -> FAULT on entering DIME with no eject_dime pulse. Also refill_dime with refill_count=255 on count 10 -> dime_count saturates at 255.
6. reset_n low during DIME pulse -> eject_dime drops asynchronously, state IDLE, counts = INV_INIT.
